// File: rtl/datapath_sequencer.sv
// Micro-sequencer: turns one accepted command word into the register-read,
// execute and writeback control cycles of the lab5 datapath.
module datapath_sequencer #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_rn,
  input  logic [RW-1:0] cmd_rm,
  input  logic [1:0]    cmd_shift,
  input  logic [DW-1:0] cmd_imm,
  output logic [RW-1:0] readnum,
  output logic          loada,
  output logic          loadb,
  output logic [1:0]    shift,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    ALUop,
  output logic          loadc,
  output logic          loads,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          vsel,
  output logic [DW-1:0] datapath_in,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB, S_WBI} state_t;

  localparam logic [2:0] OP_MOVI = 3'b000, OP_MOV = 3'b001, OP_ADD = 3'b010,
                         OP_SUB  = 3'b011, OP_AND = 3'b100, OP_CMP = 3'b101,
                         OP_MVN  = 3'b110, OP_RSV = 3'b111;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [RW-1:0]   rd_q, rn_q, rm_q;
  logic [1:0]      shift_q;
  logic [DW-1:0]   imm_q;
  logic            accept;

  assign accept = cmd_valid && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        case (cmd_op)
          OP_MOVI:        state_d = S_WBI;
          OP_MOV, OP_MVN: state_d = S_RDB;
          OP_RSV:         state_d = S_WB;
          default:        state_d = S_RDA;
        endcase
      end
      S_RDA:   state_d = S_RDB;
      S_RDB:   state_d = S_EXEC;
      S_EXEC:  state_d = (op_q == OP_CMP) ? S_IDLE : S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= cmd_op;
        rd_q    <= cmd_rd;
        rn_q    <= cmd_rn;
        rm_q    <= cmd_rm;
        shift_q <= cmd_shift;
        imm_q   <= cmd_imm;
      end
    end
  end

  // Controls are pure decode of the registered state, so reset clears them
  // asynchronously along with state_q.
  always_comb begin
    readnum  = '0;
    loada    = 1'b0;
    loadb    = 1'b0;
    shift    = 2'b00;
    asel     = 1'b0;
    ALUop    = 2'b00;
    loadc    = 1'b0;
    loads    = 1'b0;
    writenum = '0;
    write    = 1'b0;
    vsel     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_RDA: begin
        readnum = rn_q;
        loada   = 1'b1;
      end
      S_RDB: begin
        readnum = rm_q;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = shift_q;
        case (op_q)
          OP_SUB, OP_CMP: ALUop = 2'b01;
          OP_AND:         ALUop = 2'b10;
          OP_MVN:         ALUop = 2'b11;
          default:        ALUop = 2'b00;
        endcase
        asel  = (op_q == OP_MOV) || (op_q == OP_MVN);
        loadc = (op_q != OP_CMP);
        loads = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND) || (op_q == OP_CMP);
        done  = (op_q == OP_CMP);
      end
      S_WB: begin
        // The reserved op lands here only to report done+err without writing.
        writenum = rd_q;
        write    = (op_q != OP_RSV);
        err      = (op_q == OP_RSV);
        done     = 1'b1;
      end
      S_WBI: begin
        writenum = rd_q;
        write    = 1'b1;
        vsel     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bsel        = 1'b0;
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = ~cmd_ready;
  assign datapath_in = imm_q;

endmodule
